noc_inject_arbiter: RTL and testbench

- Wormhole packet arbiter sharing one NoC injection link among NUM_REQ local requesters.
- Sits between the local sources and the router-side receive port; that port has valid, ready, flit, VCready, is_header and is_tail.
- Grants the link round-robin per packet, holds the grant from header to tail, and gates injection with a virtual-channel credit counter fed by the downstream VCready return.
- Output is registered: one flit of buffering.

---
 rtl/noc_inject_arbiter.sv | 175 +++++++++++++++++
 tb/tb_noc_inject_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_inject_arbiter.sv
// Purpose : round-robin wormhole arbiter sharing one NoC injection link among NUM_REQ sources, credit gated.
// Latency : 1 cycle from req_valid/req_ready handshake to out_valid (registered output, one flit of buffering).
// Backpr. : req_ready drops when credit is exhausted or the output register is full and out_ready is low.
//
// Ports:
//   noc_clk, rst_n            clock, asynchronous active-low reset
//   req_valid/ready/flit      per-requester flit handshake; requester i flit at req_flit[i*DATA_W +: DATA_W]
//   req_is_header/is_tail     per-requester packet framing markers
//   out_valid/ready/flit      registered link output with framing markers out_is_header/out_is_tail
//   out_VCready               one-cycle credit return pulse from the downstream VC buffer
//   grant                     one-hot owner of the link while a packet is in flight, 0 when idle
//   err                       sticky protocol error; only built when NOC_ARB_PROTOCOL_CHECK_EN is defined
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_inject_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = `Noc_Data_Width,
    parameter int CREDIT_DEPTH = 4
) (
    input  logic                      noc_clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_flit,
    input  logic [NUM_REQ-1:0]        req_is_header,
    input  logic [NUM_REQ-1:0]        req_is_tail,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_flit,
    output logic                      out_is_header,
    output logic                      out_is_tail,
    input  logic                      out_VCready,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW    = $clog2(CREDIT_DEPTH + 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDIT_DEPTH);

    typedef struct packed {
        logic              hdr;
        logic              tl;
        logic [DATA_W-1:0] dat;
    } flit_t;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t             state;
    flit_t              out_q;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_vld;
    logic [CW-1:0]      credit;
    logic               can_load;
    logic               accept;
    logic               vc_inc;
    logic [DATA_W-1:0]  flit_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign flit_arr[g] = req_flit[g*DATA_W +: DATA_W];
    end

    assign can_load = (credit != '0) && (!out_valid || out_ready);

    // Idle: first header-valid requester after rr_ptr, with wrap. Locked: the owner only,
    // independent of its valid so the packet body streams without re-arbitration.
    always_comb begin
        logic [IDX_W-1:0] cand;
        sel_vld = 1'b0;
        sel_idx = owner;
        cand    = '0;
        if (state == LOCKED) begin
            sel_vld = 1'b1;
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
                if (!sel_vld && req_valid[cand] && req_is_header[cand]) begin
                    sel_vld = 1'b1;
                    sel_idx = cand;
                end
            end
        end
    end

    always_comb begin
        req_ready          = '0;
        req_ready[sel_idx] = sel_vld && can_load;
    end

    assign accept = sel_vld && can_load && req_valid[sel_idx];
    // A return while already full is bogus and must not push credit past the buffer depth.
    assign vc_inc = out_VCready && (credit != CRED_MAX);

    always_ff @(posedge noc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_q     <= '0;
            out_valid <= 1'b0;
            rr_ptr    <= IDX_W'(NUM_REQ - 1);
            owner     <= '0;
            grant     <= '0;
            credit    <= CRED_MAX;
        end else begin
            if (accept) begin
                out_q     <= '{hdr: req_is_header[sel_idx], tl: req_is_tail[sel_idx], dat: flit_arr[sel_idx]};
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case ({accept, vc_inc})
                2'b10:   credit <= credit - 1'b1;
                2'b01:   credit <= credit + 1'b1;
                default: credit <= credit;
            endcase

            if (accept) begin
                case (state)
                    IDLE: begin
                        if (req_is_tail[sel_idx]) begin
                            rr_ptr <= sel_idx;
                        end else begin
                            state <= LOCKED;
                            owner <= sel_idx;
                            grant <= NUM_REQ'(1) << sel_idx;
                        end
                    end
                    LOCKED: begin
                        if (req_is_tail[sel_idx]) begin
                            state  <= IDLE;
                            rr_ptr <= owner;
                            grant  <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign out_flit      = out_q.dat;
    assign out_is_header = out_q.hdr;
    assign out_is_tail   = out_q.tl;

`ifdef NOC_ARB_PROTOCOL_CHECK_EN
    logic err_q;
    logic proto_viol;

    // Body flit waiting while the link could take a header, a header inside a locked
    // packet, or a credit return with nothing outstanding.
    always_comb begin
        proto_viol = 1'b0;
        if ((state == IDLE) && can_load && |(req_valid & ~req_is_header))
            proto_viol = 1'b1;
        if ((state == LOCKED) && accept && req_is_header[sel_idx])
            proto_viol = 1'b1;
        if (out_VCready && (credit == CRED_MAX))
            proto_viol = 1'b1;
    end

    always_ff @(posedge noc_clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_q | proto_viol;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Purpose : directed bench for noc_inject_arbiter with a flit scoreboard on the output link.
// Latency : expects each accepted flit on out_flit one cycle after its handshake.
// Backpr. : drives out_ready stalls and withholds VC credit returns to exercise back-pressure.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module tb_noc_inject_arbiter;

    localparam int NR = 4;
    localparam int DW = `Noc_Data_Width;

    typedef struct packed {
        logic          hdr;
        logic          tl;
        logic [DW-1:0] d;
    } flit_t;

    logic              noc_clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*DW-1:0]  req_flit;
    logic [NR-1:0]     req_is_header;
    logic [NR-1:0]     req_is_tail;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_flit;
    logic              out_is_header;
    logic              out_is_tail;
    logic              out_VCready;
    logic [NR-1:0]     grant;
    logic              err;

    noc_inject_arbiter #(.NUM_REQ(NR), .DATA_W(`Noc_Data_Width), .CREDIT_DEPTH(4)) dut (
        .noc_clk       (noc_clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_flit      (req_flit),
        .req_is_header (req_is_header),
        .req_is_tail   (req_is_tail),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_flit      (out_flit),
        .out_is_header (out_is_header),
        .out_is_tail   (out_is_tail),
        .out_VCready   (out_VCready),
        .grant         (grant),
        .err           (err)
    );

    always #5 noc_clk = ~noc_clk;

    flit_t src_q [NR][$];
    flit_t exp_q [$];
    int    xfer_cyc [$];
    int    acc_cnt [NR];
    logic [3:0] vc_pipe;
    bit    auto_vc;
    int    cyc;
    int    n_chk, n_pass, n_fail;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic flit_t mk(input logic h, input logic t, input logic [DW-1:0] d);
        flit_t f;
        f.hdr = h; f.tl = t; f.d = d;
        return f;
    endfunction

    task automatic send(input int r, input flit_t f);
        src_q[r].push_back(f);
        exp_q.push_back(f);
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            if (src_q[i].size() > 0) begin
                req_valid[i]           = 1'b1;
                req_is_header[i]       = src_q[i][0].hdr;
                req_is_tail[i]         = src_q[i][0].tl;
                req_flit[i*DW +: DW]   = src_q[i][0].d;
            end else begin
                req_valid[i]           = 1'b0;
                req_is_header[i]       = 1'b0;
                req_is_tail[i]         = 1'b0;
                req_flit[i*DW +: DW]   = '0;
            end
        end
        out_VCready = vc_pipe[0];
        vc_pipe     = vc_pipe >> 1;
    endtask

    // Sample handshakes and the output link mid-cycle, then advance one clock and re-drive.
    task automatic step();
        logic [NR-1:0] acc;
        flit_t e;
        @(negedge noc_clk);
        cyc++;
        acc = req_valid & req_ready;
        for (int i = 0; i < NR; i++) if (acc[i]) acc_cnt[i]++;
        if (out_valid && out_ready) begin
            chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_flit", 64'({out_is_header, out_is_tail, out_flit}), 64'(e));
            end
            xfer_cyc.push_back(cyc);
            if (auto_vc) vc_pipe[1] = 1'b1;
        end
        @(posedge noc_clk);
        #1;
        for (int i = 0; i < NR; i++) if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        drive();
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 200 && exp_q.size() > 0; k++) step();
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NR; i++) begin src_q[i].delete(); acc_cnt[i] = 0; end
        exp_q.delete();
        xfer_cyc.delete();
        vc_pipe   = '0;
        out_ready = 1'b1;
        drive();
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_flit", 64'({out_is_header, out_is_tail, out_flit}), 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_credit", 64'(dut.credit), 64'd4);
        chk("rst_rr_ptr", 64'(dut.rr_ptr), 64'd3);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        @(negedge noc_clk);
        rst_n = 1'b1;
        @(posedge noc_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_pass = 0; n_fail = 0; cyc = 0;
        req_valid = '0; req_is_header = '0; req_is_tail = '0; req_flit = '0;
        out_VCready = 1'b0; out_ready = 1'b1; auto_vc = 1'b1; vc_pipe = '0;
        rst_n = 1'b1;
        @(posedge noc_clk);
        #1;

        // 1: single 3-flit packet from req1, credits returned two cycles after each flit.
        do_reset();
        send(1, mk(1'b1, 1'b0, 32'hA1));
        send(1, mk(1'b0, 1'b0, 32'hA2));
        send(1, mk(1'b0, 1'b1, 32'hA3));
        drive();
        step();
        chk("t1_grant_h", 64'(grant), 64'b0010);
        chk("t1_flit_h", 64'(out_flit), 64'hA1);
        step();
        chk("t1_grant_b", 64'(grant), 64'b0010);
        chk("t1_flit_b", 64'(out_flit), 64'hA2);
        step();
        chk("t1_grant_after_tail", 64'(grant), 64'd0);
        chk("t1_flit_t", 64'(out_flit), 64'hA3);
        drain("t1_drain");
        chk("t1_xfer_count", 64'(xfer_cyc.size()), 64'd3);
        if (xfer_cyc.size() == 3) begin
            chk("t1_consec_1", 64'(xfer_cyc[1] - xfer_cyc[0]), 64'd1);
            chk("t1_consec_2", 64'(xfer_cyc[2] - xfer_cyc[1]), 64'd1);
        end
        for (int k = 0; k < 5; k++) step();
        chk("t1_credit_end", 64'(dut.credit), 64'd4);

        // 2: all four requesters offer 2-flit packets at once; served 0,1,2,3 without interleave.
        do_reset();
        for (int r = 0; r < NR; r++) begin
            send(r, mk(1'b1, 1'b0, DW'(32'h10 * r + 32'h1)));
            send(r, mk(1'b0, 1'b1, DW'(32'h10 * r + 32'h2)));
        end
        drive();
        drain("t2_drain");
        chk("t2_grant_idle", 64'(grant), 64'd0);

        // 3: no credit returns, 6-flit packet from req0: four accepted, then one per returned credit.
        do_reset();
        auto_vc = 1'b0;
        send(0, mk(1'b1, 1'b0, 32'hB0));
        for (int k = 1; k < 5; k++) send(0, mk(1'b0, 1'b0, DW'(32'hB0 + k)));
        send(0, mk(1'b0, 1'b1, 32'hB5));
        drive();
        for (int k = 0; k < 8; k++) step();
        chk("t3_acc_4", 64'(acc_cnt[0]), 64'd4);
        chk("t3_ready_low", 64'(req_ready[0]), 64'd0);
        chk("t3_credit_0", 64'(dut.credit), 64'd0);
        vc_pipe[0] = 1'b1;
        step();
        step();
        chk("t3_credit_1", 64'(dut.credit), 64'd1);
        chk("t3_ready_back", 64'(req_ready[0]), 64'd1);
        step();
        chk("t3_acc_5", 64'(acc_cnt[0]), 64'd5);
        for (int k = 0; k < 3; k++) step();
        chk("t3_acc_still_5", 64'(acc_cnt[0]), 64'd5);
        chk("t3_ready_low2", 64'(req_ready[0]), 64'd0);
        auto_vc = 1'b1;

        // 4: out_ready low for 5 cycles mid-packet: output holds, no accepts, nothing lost.
        do_reset();
        for (int k = 0; k < 4; k++) send(2, mk(k == 0, k == 3, DW'(32'hC1 + k)));
        drive();
        step();
        step();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t4_hold_flit", 64'(out_flit), 64'hC2);
            chk("t4_hold_valid", 64'(out_valid), 64'd1);
            chk("t4_ready_low", 64'(req_ready[2]), 64'd0);
        end
        out_ready = 1'b1;
        drain("t4_drain");
        chk("t4_acc_4", 64'(acc_cnt[2]), 64'd4);

        // 5: single-flit packets from req2 and req3 back to back: never locked, rr_ptr 2 then 3.
        do_reset();
        send(2, mk(1'b1, 1'b1, 32'hD2));
        send(3, mk(1'b1, 1'b1, 32'hD3));
        drive();
        step();
        chk("t5_rr_2", 64'(dut.rr_ptr), 64'd2);
        chk("t5_grant_0a", 64'(grant), 64'd0);
        step();
        chk("t5_rr_3", 64'(dut.rr_ptr), 64'd3);
        chk("t5_grant_0b", 64'(grant), 64'd0);
        drain("t5_drain");

        // 6: body flit from req1 while idle.
        do_reset();
        src_q[1].push_back(mk(1'b0, 1'b0, 32'hE1));
        drive();
        chk("t6_err_pre", 64'(err), 64'd0);
        step();
`ifdef NOC_ARB_PROTOCOL_CHECK_EN
        chk("t6_err_set", 64'(err), 64'd1);
`else
        chk("t6_err_tied", 64'(err), 64'd0);
`endif
        chk("t6_not_accepted", 64'(acc_cnt[1]), 64'd0);
        src_q[1].delete();
        drive();
        for (int k = 0; k < 3; k++) step();
`ifdef NOC_ARB_PROTOCOL_CHECK_EN
        chk("t6_err_sticky", 64'(err), 64'd1);
`else
        chk("t6_err_still_0", 64'(err), 64'd0);
`endif
        do_reset();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
